// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: 16-bit unsigned binary to four BCD digits.
// Values above 9999 saturate to 9999 and raise overflow.
module bin_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       bcd_out [0:DIGITS-1]
);

  localparam int SCR_W = 4 * (DIGITS + 1);
  localparam int OUT_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [OUT_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   adj;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, shift_d} = {adj[SCR_W-2:0], shift_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15)
          state_d = S_DONE;
      end
      S_DONE: begin
        // a nonzero ten-thousands digit is the only way to exceed 9999
        if (scr_q[SCR_W-1 -: 4] != 4'd0) begin
          bcd_d = {DIGITS{4'd9}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = scr_q[OUT_W-1:0];
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      bcd_out[i] = bcd_q[4*(DIGITS-1-i) +: 4];
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed table-driven bench for bin_to_bcd plus hand-written
// sequences for ignored start, reset abort and back-to-back conversions.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  bcd_out [0:3];

  int n_pass = 0;
  int n_tot  = 0;

  bin_to_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] digits;
    logic        ovf;
  } vec_t;

  vec_t vecs [0:8];

  function automatic logic [15:0] dig();
    return {bcd_out[0], bcd_out[1], bcd_out[2], bcd_out[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // issue start for one edge, return clocks until done (0 = timeout)
  task automatic run(input logic [15:0] v, output int lat);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;
  logic [15:0] prev;

  initial begin
    vecs[0] = '{16'd0,     16'h0000, 1'b0};
    vecs[1] = '{16'd1234,  16'h1234, 1'b0};
    vecs[2] = '{16'd9999,  16'h9999, 1'b0};
    vecs[3] = '{16'd5678,  16'h5678, 1'b0};
    vecs[4] = '{16'd42,    16'h0042, 1'b0};
    vecs[5] = '{16'd305,   16'h0305, 1'b0};
    vecs[6] = '{16'd10000, 16'h9999, 1'b1};
    vecs[7] = '{16'd65535, 16'h9999, 1'b1};
    vecs[8] = '{16'd8090,  16'h8090, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_bcd", dig(), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);

    foreach (vecs[i]) begin
      run(vecs[i].bin, lat);
      chk($sformatf("lat_%0d", vecs[i].bin), lat, 17);
      chk($sformatf("bcd_%0d", vecs[i].bin), dig(), vecs[i].digits);
      chk($sformatf("ovf_%0d", vecs[i].bin), overflow, vecs[i].ovf);
      chk($sformatf("busy_done_%0d", vecs[i].bin), busy, 0);
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse_%0d", vecs[i].bin), done, 0);
    end

    // start and bin_in changes while busy are ignored; outputs hold
    prev = dig();
    fork
      run(16'd1234, lat);
      begin
        repeat (5) @(negedge clk);
        bin_in = 16'd9876;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("hold_while_busy", dig(), prev);
      end
    join
    chk("ign_lat", lat, 17);
    chk("ign_bcd", dig(), 16'h1234);

    // back-to-back: start asserted during the done cycle
    run(16'd4321, lat);
    chk("b2b_lat", lat, 17);
    chk("b2b_bcd", dig(), 16'h4321);

    // reset mid-conversion aborts with no done
    @(negedge clk);
    bin_in = 16'd777;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", dig(), 0);
    chk("abort_ovf", overflow, 0);
    lat = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
    chk("abort_no_done", lat, 0);

    // rst wins over start
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    bin_in = 16'd55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("rst_wins_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
